// File: rtl/risc_pkg.sv
// risc_pkg: controller state encoding, opcode values and instruction field positions
package risc_pkg;
  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_ALU, S_WRITE_REG
  } state_t;
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;
  localparam int OPC_LSB = 13;
  localparam int OP_LSB = 11;
  localparam int RN_LSB = 8;
  localparam int RD_LSB = 5;
  localparam int SH_LSB = 3;
  localparam int RM_LSB = 0;
endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: splits the IR into fields, sign-extends imm8 and classifies the instruction
module instr_decoder
  import risc_pkg::*;
(
  input  logic [15:0] ir,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [2:0]  rm,
  output logic [1:0]  op,
  output logic [1:0]  sh,
  output logic [15:0] sximm8,
  output logic        mov_imm,
  output logic        mov_reg,
  output logic        alu,
  output logic        cmp,
  output logic        illegal
);
  logic [2:0] opcode;
  assign opcode  = ir[OPC_LSB +: 3];
  assign op      = ir[OP_LSB +: 2];
  assign rn      = ir[RN_LSB +: 3];
  assign rd      = ir[RD_LSB +: 3];
  assign sh      = ir[SH_LSB +: 2];
  assign rm      = ir[RM_LSB +: 3];
  assign sximm8  = {{8{ir[7]}}, ir[7:0]};
  assign mov_imm = opcode == OPC_MOV && op == OP_MOV_IMM;
  assign mov_reg = opcode == OPC_MOV && op == OP_MOV_REG;
  assign cmp     = opcode == OPC_ALU && op == OP_CMP;
  assign alu     = opcode == OPC_ALU && op != OP_CMP;
  assign illegal = !(mov_imm || mov_reg || cmp || alu);
endmodule

// File: rtl/vDFF.sv
// vDFF: plain n-bit rising-edge register
module vDFF #(parameter int n = 1) (
  input  logic         clk,
  input  logic [n-1:0] D,
  output logic [n-1:0] Q
);
  // capture D every edge
  always_ff @(posedge clk) Q <= D;
endmodule

// File: rtl/risc_controller.sv
// risc_controller: instruction register plus multi-cycle FSM sequencing the datapath controls
module risc_controller
  import risc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        write,
  output logic        asel,
  output logic        bsel,
  output logic        vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] datapath_in
);
  state_t state, nxt;
  logic [15:0] ir;
  logic [2:0] rn, rd, rm;
  logic [1:0] op, sh;
  logic mov_imm, mov_reg, alu, cmp, illegal;
  vDFF #(16) ir_reg (.clk, .D(reset ? 16'h0 : (load && state == S_WAIT) ? in : ir), .Q(ir));
  instr_decoder dec (
    .ir, .rn, .rd, .rm, .op, .sh, .sximm8(datapath_in),
    .mov_imm, .mov_reg, .alu, .cmp, .illegal
  );
  assign bsel = 1'b0;
  // next state from the current state and the decoded IR
  always_comb
    nxt = state == S_WAIT   ? (s ? S_DECODE : S_WAIT) :
          state == S_DECODE ? (illegal ? S_WAIT : mov_imm ? S_WRITE_IMM :
                               (mov_reg || (alu && op == OP_MVN)) ? S_GET_B : S_GET_A) :
          state == S_GET_A  ? S_GET_B :
          state == S_GET_B  ? S_ALU :
          state == S_ALU    ? (cmp ? S_WAIT : S_WRITE_REG) : S_WAIT;
  // state and outputs registered together so outputs always match the state being entered
  always_ff @(posedge clk)
    if (reset) begin
      state    <= S_WAIT;
      w        <= 1'b1;
      readnum  <= 3'd0;
      writenum <= 3'd0;
      loada    <= 1'b0;
      loadb    <= 1'b0;
      loadc    <= 1'b0;
      loads    <= 1'b0;
      write    <= 1'b0;
      asel     <= 1'b0;
      vsel     <= 1'b0;
      shift    <= 2'd0;
      ALUop    <= 2'd0;
    end else begin
      state    <= nxt;
      w        <= nxt == S_WAIT;
      readnum  <= nxt == S_GET_A ? rn : nxt == S_GET_B ? rm : 3'd0;
      writenum <= nxt == S_WRITE_REG ? rd : nxt == S_WRITE_IMM ? rn : 3'd0;
      loada    <= nxt == S_GET_A;
      loadb    <= nxt == S_GET_B;
      loadc    <= nxt == S_ALU && !cmp;
      loads    <= nxt == S_ALU && cmp;
      write    <= nxt == S_WRITE_REG || nxt == S_WRITE_IMM;
      asel     <= nxt == S_ALU && mov_reg;
      vsel     <= nxt == S_WRITE_IMM;
      shift    <= nxt == S_ALU ? sh : 2'd0;
      ALUop    <= (nxt == S_ALU && !mov_reg) ? op : 2'd0;
    end
endmodule
